filter_window_ctrl: RTL and testbench

Sequencer for the stream_video_filter datapath. It watches the AXI4-Stream video handshake and sideband on the filter input and derives pixel/line coordinates, line-buffer write control, line-buffer row rotation and the window-valid qualifier for the FILTER_CORE_DIM x FILTER_CORE_DIM kernel. It also checks framing: SOF placement and line length against the first line of the frame. It never stalls the stream; it only observes it and drives the line buffers and the kernel.

---
 rtl/filter_pkg.sv | 23 ++
 rtl/filter_window_ctrl_if.sv | 10 +
 rtl/filter_line_meter.sv | 78 +++++++
 rtl/filter_window_ctrl.sv | 131 +++++++++++++
 tb/tb_filter_window_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared types and helpers for the stream video filter window sequencer.
package filter_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam int DEF_CORE_DIM  = 5;
    localparam int DEF_MAX_WIDTH = 2048;
    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_CNT_W     = 12;

    // Kernel radius: distance from the window centre to its edge.
    function automatic int kernel_radius(input int dim);
        return (dim - 1) / 2;
    endfunction

    function automatic int row_sel_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/filter_window_ctrl_if.sv
// Observed AXI4-Stream video handshake and sideband at the filter input.
interface filter_window_ctrl_if;
    logic tvalid;
    logic tready;
    logic tuser;
    logic tlast;

    modport master (output tvalid, tready, tuser, tlast);
    modport slave  (input  tvalid, tready, tuser, tlast);
endinterface

// File: rtl/filter_line_meter.sv
// Column counter plus line-length learning and early/late end-of-line checks.
module filter_line_meter
    import filter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat,
    input  logic             tlast,
    input  logic             sof,
    input  logic             first_line,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] col,
    output logic             eol,
    output logic [CNT_W-1:0] line_width,
    output logic             eol_early,
    output logic             eol_late
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] lw_reg;
    logic             late_seen_reg;
    logic             early_reg;
    logic             late_reg;
    logic             first;
    logic [CNT_W-1:0] col_inc;

    // An SOF beat always lands in column 0 of line 0, whatever x held before.
    always_comb begin
        col     = sof ? '0 : x_reg;
        first   = sof | first_line;
        col_inc = (col == CNT_MAX) ? col : col + 1'b1;
        eol     = beat & tlast;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg         <= '0;
            lw_reg        <= '0;
            late_seen_reg <= 1'b0;
            early_reg     <= 1'b0;
            late_reg      <= 1'b0;
        end else begin
            early_reg <= 1'b0;
            late_reg  <= 1'b0;
            if (beat) begin
                if (tlast) begin
                    x_reg         <= '0;
                    late_seen_reg <= 1'b0;
                    if (first)
                        lw_reg <= col_inc;
                    else
                        early_reg <= (col_inc < lw_reg);
                end else begin
                    x_reg <= col_inc;
                    if (sof) begin
                        lw_reg        <= '0;
                        late_seen_reg <= 1'b0;
                    end
                    // late_seen guards against repeats once x saturates
                    if (!first && !late_seen_reg && (col == lw_reg - 1'b1)) begin
                        late_reg      <= 1'b1;
                        late_seen_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign x          = x_reg;
    assign line_width = lw_reg;
    assign eol_early  = early_reg;
    assign eol_late   = late_reg;

endmodule

// File: rtl/filter_window_ctrl.sv
// Observes the filter-input stream and sequences line-buffer writes and window qualification.
module filter_window_ctrl
    import filter_pkg::*;
#(
    parameter int FILTER_CORE_DIM = DEF_CORE_DIM,
    parameter int MAX_WIDTH       = DEF_MAX_WIDTH,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    filter_window_ctrl_if.slave                   vid,
    output logic                                  lb_wr_en,
    output logic [ADDR_W-1:0]                     lb_wr_addr,
    output logic [row_sel_w(FILTER_CORE_DIM)-1:0] lb_wr_sel,
    output logic [CNT_W-1:0]                      pix_x,
    output logic [CNT_W-1:0]                      pix_y,
    output logic                                  win_valid,
    output logic [CNT_W-1:0]                      line_width,
    output logic [CNT_W-1:0]                      frame_height,
    output logic                                  frame_done,
    output logic                                  sof_err,
    output logic                                  eol_early,
    output logic                                  eol_late,
    output logic                                  busy
);

    localparam int               SEL_W    = row_sel_w(FILTER_CORE_DIM);
    localparam int               R        = kernel_radius(FILTER_CORE_DIM);
    localparam logic [CNT_W-1:0] EDGE     = CNT_W'(2 * R);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(FILTER_CORE_DIM - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] y_reg;
    logic [SEL_W-1:0] sel_reg;

    logic             beat;
    logic             sof;
    logic             frame_beat;
    logic             first_line;
    logic [CNT_W-1:0] y_eff;
    logic [SEL_W-1:0] sel_eff;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] col;
    logic             eol;

    // Beats outside a frame (no SOF seen yet) never reach the line buffers.
    always_comb begin
        beat       = vid.tvalid & vid.tready;
        sof        = beat & vid.tuser;
        frame_beat = beat & ((state_reg == ACTIVE) | vid.tuser);
        first_line = (y_reg == '0);
        y_eff      = sof ? '0 : y_reg;
        sel_eff    = sof ? '0 : sel_reg;
    end

    filter_line_meter #(
        .CNT_W (CNT_W)
    ) u_line_meter (
        .clk        (clk),
        .reset      (reset),
        .beat       (frame_beat),
        .tlast      (vid.tlast),
        .sof        (sof),
        .first_line (first_line),
        .x          (x),
        .col        (col),
        .eol        (eol),
        .line_width (line_width),
        .eol_early  (eol_early),
        .eol_late   (eol_late)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= WAIT_SOF;
            y_reg        <= '0;
            sel_reg      <= '0;
            lb_wr_en     <= 1'b0;
            lb_wr_addr   <= '0;
            lb_wr_sel    <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            win_valid    <= 1'b0;
            frame_height <= '0;
            frame_done   <= 1'b0;
            sof_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            lb_wr_en   <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;

            if (beat && !frame_beat)
                sof_err <= 1'b1;

            if (frame_beat) begin
                state_reg <= ACTIVE;
                busy      <= 1'b1;
                // SOF mid-line aborts the frame; SOF on a line boundary closes it.
                if (sof && state_reg == ACTIVE) begin
                    if (x != '0)
                        sof_err <= 1'b1;
                    else if (y_reg != '0) begin
                        frame_height <= y_reg;
                        frame_done   <= 1'b1;
                    end
                end

                lb_wr_en   <= (col < MAX_C);
                lb_wr_addr <= col[ADDR_W-1:0];
                lb_wr_sel  <= sel_eff;
                pix_x      <= col;
                pix_y      <= y_eff;
                win_valid  <= (col < MAX_C) && (col >= EDGE) && (y_eff >= EDGE);

                if (eol) begin
                    y_reg   <= (y_eff == CNT_MAX) ? y_eff : y_eff + 1'b1;
                    sel_reg <= (sel_eff == SEL_LAST) ? '0 : sel_eff + 1'b1;
                end else begin
                    y_reg   <= y_eff;
                    sel_reg <= sel_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Randomized bench for filter_window_ctrl against a frame/line-level reference model.
module tb_filter_window_ctrl;

    localparam int DIM       = 5;
    localparam int MAX_WIDTH = 2048;
    localparam int ADDR_W    = 11;
    localparam int CNT_W     = 12;
    localparam int SEL_W     = 3;

    logic clk = 1'b0;
    logic reset;

    filter_window_ctrl_if vid ();

    logic              lb_wr_en;
    logic [ADDR_W-1:0] lb_wr_addr;
    logic [SEL_W-1:0]  lb_wr_sel;
    logic [CNT_W-1:0]  pix_x;
    logic [CNT_W-1:0]  pix_y;
    logic              win_valid;
    logic [CNT_W-1:0]  line_width;
    logic [CNT_W-1:0]  frame_height;
    logic              frame_done;
    logic              sof_err;
    logic              eol_early;
    logic              eol_late;
    logic              busy;

    filter_window_ctrl #(
        .FILTER_CORE_DIM (DIM),
        .MAX_WIDTH       (MAX_WIDTH),
        .ADDR_W          (ADDR_W),
        .CNT_W           (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vid          (vid.slave),
        .lb_wr_en     (lb_wr_en),
        .lb_wr_addr   (lb_wr_addr),
        .lb_wr_sel    (lb_wr_sel),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .win_valid    (win_valid),
        .line_width   (line_width),
        .frame_height (frame_height),
        .frame_done   (frame_done),
        .sof_err      (sof_err),
        .eol_early    (eol_early),
        .eol_late     (eol_late),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tuser, tlast;
        bit wr, win, serr, fdone, early, late;
        int x, y, sel, lw, fh;
    } beat_t;

    beat_t q[$];

    // Frame-level model state
    bit m_in;
    int m_lines;
    int m_pos;
    int m_w;
    int m_fh;

    int cur_lw, cur_fh;
    bit cur_busy;
    int win_seen;

    int compared   = 0;
    int mismatched = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_junk();
        beat_t b;
        b = '{default: 0};
        b.serr = 1'b1;
        b.lw   = m_w;
        b.fh   = m_fh;
        q.push_back(b);
    endtask

    // One line of len beats; optional SOF on its first beat, optional tlast on its last.
    task automatic add_line(input int len, input bit sof, input bit end_tlast);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b = '{default: 0};
            b.tuser = sof && (k == 0);
            b.tlast = end_tlast && (k == len - 1);
            if (b.tuser) begin
                b.fdone = m_in && (m_pos == 0) && (m_lines > 0);
                b.serr  = m_in && (m_pos != 0);
                if (b.fdone) m_fh = m_lines;
                m_in = 1'b1; m_lines = 0; m_pos = 0; m_w = 0;
            end
            b.wr  = 1'b1;
            b.x   = m_pos;
            b.y   = m_lines;
            b.sel = m_lines % DIM;
            b.win = (m_pos >= DIM - 1) && (m_lines >= DIM - 1);
            b.late = (m_lines > 0) && (m_pos == m_w - 1) && !b.tlast;
            if (b.tlast) begin
                b.early = (m_lines > 0) && (m_pos + 1 < m_w);
                if (m_lines == 0) m_w = m_pos + 1;
                m_lines++;
                m_pos = 0;
            end else begin
                m_pos++;
            end
            b.lw = m_w;
            b.fh = m_fh;
            q.push_back(b);
        end
    endtask

    task automatic check_pulses(input beat_t b);
        check_val("lb_wr_en",     32'(lb_wr_en),     32'(b.wr));
        check_val("win_valid",    32'(win_valid),    32'(b.win));
        check_val("sof_err",      32'(sof_err),      32'(b.serr));
        check_val("frame_done",   32'(frame_done),   32'(b.fdone));
        check_val("eol_early",    32'(eol_early),    32'(b.early));
        check_val("eol_late",     32'(eol_late),     32'(b.late));
        check_val("line_width",   32'(line_width),   32'(cur_lw));
        check_val("frame_height", 32'(frame_height), 32'(cur_fh));
        check_val("busy",         32'(busy),         32'(cur_busy));
    endtask

    task automatic run_queue(input bit rnd, input string name);
        int guard = 0;
        int nbeats = 0;
        while (q.size() > 0 && guard < 20000) begin
            beat_t b;
            b = q[0];
            vid.tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            vid.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            vid.tuser  = vid.tvalid ? b.tuser : 1'($urandom_range(0, 1));
            vid.tlast  = vid.tvalid ? b.tlast : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (vid.tvalid && vid.tready) begin
                void'(q.pop_front());
                cur_lw   = b.lw;
                cur_fh   = b.fh;
                cur_busy = cur_busy | b.wr;
                check_pulses(b);
                if (b.wr) begin
                    check_val("lb_wr_addr", 32'(lb_wr_addr), 32'(b.x));
                    check_val("pix_x",      32'(pix_x),      32'(b.x));
                    check_val("pix_y",      32'(pix_y),      32'(b.y));
                    check_val("lb_wr_sel",  32'(lb_wr_sel),  32'(b.sel));
                end
                if (win_valid) win_seen++;
                nbeats++;
            end else begin
                beat_t idle;
                idle = '{default: 0};
                check_pulses(idle);
            end
            guard++;
        end
        check_val("queue_drained", 32'(q.size()), 32'd0);
        q.delete();
        vid.tvalid = 1'b0;
        vid.tready = 1'b0;
        $display("run %-12s beats=%0d cycles=%0d compared=%0d", name, nbeats, guard, compared);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_wr_en"},  32'(lb_wr_en),     32'd0);
        check_val({tag, "_addr"},   32'(lb_wr_addr),   32'd0);
        check_val({tag, "_sel"},    32'(lb_wr_sel),    32'd0);
        check_val({tag, "_pix_x"},  32'(pix_x),        32'd0);
        check_val({tag, "_pix_y"},  32'(pix_y),        32'd0);
        check_val({tag, "_win"},    32'(win_valid),    32'd0);
        check_val({tag, "_lw"},     32'(line_width),   32'd0);
        check_val({tag, "_fh"},     32'(frame_height), 32'd0);
        check_val({tag, "_fdone"},  32'(frame_done),   32'd0);
        check_val({tag, "_serr"},   32'(sof_err),      32'd0);
        check_val({tag, "_early"},  32'(eol_early),    32'd0);
        check_val({tag, "_late"},   32'(eol_late),     32'd0);
        check_val({tag, "_busy"},   32'(busy),         32'd0);
    endtask

    task automatic model_reset();
        m_in = 1'b0; m_lines = 0; m_pos = 0; m_w = 0; m_fh = 0;
        cur_lw = 0; cur_fh = 0; cur_busy = 1'b0;
    endtask

    initial begin
        vid.tvalid = 1'b0;
        vid.tready = 1'b0;
        vid.tuser  = 1'b0;
        vid.tlast  = 1'b0;
        reset      = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Beats before any SOF are dropped
        repeat (3) add_junk();
        run_queue(1'b0, "pre_sof");

        // Regular 20x10 frame
        add_line(20, 1'b1, 1'b1);
        for (int j = 1; j < 10; j++) add_line(20, 1'b0, 1'b1);
        win_seen = 0;
        run_queue(1'b0, "frame_20x10");
        check_val("win_count_frame", 32'(win_seen), 32'd96);

        // Early and late line ends; opening SOF closes the 10-line frame
        add_line(20, 1'b1, 1'b1);
        add_line(20, 1'b0, 1'b1);
        add_line(20, 1'b0, 1'b1);
        add_line(15, 1'b0, 1'b1);
        add_line(20, 1'b0, 1'b1);
        add_line(23, 1'b0, 1'b1);
        add_line(20, 1'b0, 1'b1);
        run_queue(1'b0, "early_late");

        // Single-beat lines with SOF and tlast together
        add_line(1, 1'b1, 1'b1);
        add_line(1, 1'b0, 1'b1);
        run_queue(1'b0, "sof_and_eol");

        // Mid-line SOF at x=7 of line 2
        add_line(20, 1'b1, 1'b1);
        add_line(20, 1'b0, 1'b1);
        add_line(7, 1'b0, 1'b0);
        run_queue(1'b0, "mid_line_pre");

        for (int f = 0; f < 3; f++) begin
            int w, h;
            w = $urandom_range(6, 30);
            h = $urandom_range(6, 12);
            for (int j = 0; j < h; j++) begin
                int len, r;
                len = w;
                r = $urandom_range(0, 9);
                if (j > 0 && r == 0) len = $urandom_range(1, w - 1);
                if (j > 0 && r == 1) len = w + $urandom_range(1, 5);
                add_line(len, j == 0, 1'b1);
            end
        end
        run_queue(1'b1, "random_frames");

        // Reset in the middle of line 6 with throttled handshake
        add_line(20, 1'b1, 1'b1);
        for (int j = 1; j < 6; j++) add_line(20, 1'b0, 1'b1);
        add_line(5, 1'b0, 1'b0);
        run_queue(1'b1, "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("post_rst");

        add_junk();
        add_line(8, 1'b1, 1'b1);
        add_line(8, 1'b0, 1'b1);
        run_queue(1'b1, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
